register_read_port: RTL and testbench

- Host-facing read responder for a bank of register_rw-style registers; the read-side counterpart to the write/load path.
- Accepts single or burst read requests on an active-low strobe.
- Snapshots the whole bank atomically on acceptance, so multi-word reads are coherent.
- Returns one word per cycle with valid/last flags; sits between the HPS/Avalon bridge and the GPU register bank.

---
 rtl/register_read_port_pkg.sv | 14 +
 rtl/register_read_port_if.sv | 25 ++
 rtl/register_snapshot.sv | 37 +++
 rtl/register_read_port.sv | 120 ++++++++++++
 tb/tb_register_read_port.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/register_read_port_pkg.sv
// Shared types and constants for the GPU register read path.
package gpu_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_REGS = 8;

    localparam logic [DEF_WIDTH-1:0] RD_ZERO = '0;

endpackage

// File: rtl/register_read_port_if.sv
// Host-side read request / read data bundle between the bridge and the read port.
interface register_read_port_if #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 3,
    parameter int BURST_W = 4
);
    logic               rd_n;
    logic [ADDR_W-1:0]  rd_addr;
    logic [BURST_W-1:0] rd_burst;
    logic               waitrequest;
    logic [WIDTH-1:0]   rd_data;
    logic               rd_valid;
    logic               rd_last;
    logic               busy;

    modport master (
        output rd_n, rd_addr, rd_burst,
        input  waitrequest, rd_data, rd_valid, rd_last, busy
    );

    modport slave (
        input  rd_n, rd_addr, rd_burst,
        output waitrequest, rd_data, rd_valid, rd_last, busy
    );
endinterface

// File: rtl/register_snapshot.sv
// Shadow copy of the register bank, loaded in one cycle by a capture strobe.
// Latency: capture visible the cycle after the strobe; read port is combinational.
// Backpressure: none; capture is unconditional when strobed.
module register_snapshot
    import gpu_reg_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      capture,
    input  logic [NUM_REGS*WIDTH-1:0] cap_data,
    input  logic [ADDR_W-1:0]         rd_idx,
    output logic [WIDTH-1:0]          rd_word
);

    logic [WIDTH-1:0] shadow [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= cap_data[i*WIDTH +: WIDTH];
        end
    end

    // Indices beyond the populated bank read as zero.
    always_comb begin
        rd_word = WIDTH'(RD_ZERO);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(rd_idx) == i) rd_word = shadow[i];
        end
    end

endmodule

// File: rtl/register_read_port.sv
// Burst read responder over a coherent snapshot of the register bank.
// Latency: first beat one cycle after acceptance, then one beat per cycle.
// Backpressure: waitrequest high while a burst is running; no backpressure on read data.
module register_read_port
    import gpu_reg_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int ADDR_W    = 3,
    parameter int BURST_W   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REGS*WIDTH-1:0] regs_in,
    register_read_port_if.slave       bus
);

    rd_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               capture;
    logic [BURST_W-1:0] req_len;
    logic [WIDTH-1:0]   live_word;
    logic [WIDTH-1:0]   shadow_word;

    register_snapshot #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_snapshot (
        .clk      (clk),
        .reset    (reset),
        .capture  (capture),
        .cap_data (regs_in),
        .rd_idx   (ptr_q),
        .rd_word  (shadow_word)
    );

    // Zero-length requests return one word; long ones are clamped.
    always_comb begin
        if (bus.rd_burst == '0)
            req_len = BURST_W'(1);
        else if (int'(bus.rd_burst) > MAX_BURST)
            req_len = BURST_W'(MAX_BURST);
        else
            req_len = bus.rd_burst;
    end

    // First beat comes straight from the live bank; it equals what the shadow captures.
    always_comb begin
        live_word = WIDTH'(RD_ZERO);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(bus.rd_addr) == i) live_word = regs_in[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.rd_n) begin
                    capture = 1'b1;
                    data_d  = live_word;
                    valid_d = 1'b1;
                    last_d  = (req_len == BURST_W'(1));
                    ptr_d   = bus.rd_addr + ADDR_W'(1);
                    rem_d   = req_len - BURST_W'(1);
                    if (req_len != BURST_W'(1)) state_d = BURST;
                end
            end
            BURST: begin
                data_d  = shadow_word;
                valid_d = 1'b1;
                ptr_d   = ptr_q + ADDR_W'(1);
                rem_d   = rem_q - BURST_W'(1);
                if (rem_q == BURST_W'(1)) begin
                    last_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // waitrequest falls in the cycle the last beat is presented, allowing gap-free chaining.
    assign bus.waitrequest = (state_q == BURST);
    assign bus.busy        = (state_q == BURST);
    assign bus.rd_data     = data_q;
    assign bus.rd_valid    = valid_q;
    assign bus.rd_last     = last_q;

endmodule

// File: tb/tb_register_read_port.sv
// Randomized and directed bench for register_read_port against a queue-based beat model.
module tb_register_read_port;

    localparam int WIDTH     = 32;
    localparam int NUM_REGS  = 8;
    localparam int ADDR_W    = 3;
    localparam int BURST_W   = 4;
    localparam int MAX_BURST = 8;

    logic clk = 1'b0;
    logic reset;
    logic [WIDTH-1:0]          regs [NUM_REGS];
    logic [NUM_REGS*WIDTH-1:0] regs_in;

    register_read_port_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign regs_in[g*WIDTH +: WIDTH] = regs[g];
    end

    register_read_port #(
        .WIDTH     (WIDTH),
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .BURST_W   (BURST_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .regs_in (regs_in),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: words still owed to the host, plus the expected registered outputs.
    logic [WIDTH-1:0] pend [$];
    logic [WIDTH-1:0] e_data  = '0;
    logic             e_valid = 1'b0;
    logic             e_last  = 1'b0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int len;
        int idx;
        if (!reset) begin
            pend.delete();
            e_data  = '0;
            e_valid = 1'b0;
            e_last  = 1'b0;
        end else if (pend.size() > 0) begin
            e_data  = pend.pop_front();
            e_valid = 1'b1;
            e_last  = (pend.size() == 0);
        end else if (!bus.rd_n) begin
            len = int'(bus.rd_burst);
            if (len == 0) len = 1;
            if (len > MAX_BURST) len = MAX_BURST;
            for (int i = 0; i < len; i++) begin
                idx = (int'(bus.rd_addr) + i) % (1 << ADDR_W);
                pend.push_back(idx < NUM_REGS ? regs[idx] : '0);
            end
            e_data  = pend.pop_front();
            e_valid = 1'b1;
            e_last  = (len == 1);
        end else begin
            e_valid = 1'b0;
            e_last  = 1'b0;
        end
    endtask

    task automatic cycle(input logic rst, input logic rdn, input int addr, input int burst);
        logic [31:0] a;
        logic [31:0] b;
        a = addr;
        b = burst;
        @(negedge clk);
        reset        = rst;
        bus.rd_n     = rdn;
        bus.rd_addr  = a[ADDR_W-1:0];
        bus.rd_burst = b[BURST_W-1:0];
        model_step();
        @(posedge clk);
        #1;
        chk("rd_valid",    WIDTH'(bus.rd_valid),    WIDTH'(e_valid));
        chk("rd_last",     WIDTH'(bus.rd_last),     WIDTH'(e_last));
        chk("rd_data",     bus.rd_data,             e_data);
        chk("waitrequest", WIDTH'(bus.waitrequest), WIDTH'(pend.size() > 0));
        chk("busy",        WIDTH'(bus.busy),        WIDTH'(pend.size() > 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 0, 0);
    endtask

    initial begin
        reset        = 1'b0;
        bus.rd_n     = 1'b0;
        bus.rd_addr  = '0;
        bus.rd_burst = '0;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h1000_0000 + i;

        // Reset held with a pending strobe: nothing must come out.
        repeat (3) cycle(1'b0, 1'b0, 3, 1);
        cycle(1'b1, 1'b0, 3, 1);
        idle(1);

        // Single read.
        regs[5] = 32'hCAFEF00D;
        cycle(1'b1, 1'b0, 5, 1);
        chk("single_data", bus.rd_data, 32'hCAFEF00D);
        idle(1);

        // Coherent burst: bank changes after acceptance must not leak in.
        for (int i = 0; i < NUM_REGS; i++) regs[i] = i * 32'h1111;
        cycle(1'b1, 1'b0, 6, 4);
        regs[7] = '0;
        regs[0] = 32'hFFFF_FFFF;
        cycle(1'b1, 1'b1, 0, 0);
        chk("coherent_b2", bus.rd_data, 32'h7777);
        cycle(1'b1, 1'b1, 0, 0);
        chk("coherent_b3", bus.rd_data, 32'h0000);
        cycle(1'b1, 1'b1, 0, 0);
        chk("coherent_b4", bus.rd_data, 32'h1111);
        idle(1);

        // Length edge cases.
        cycle(1'b1, 1'b0, 4, 0);
        idle(2);
        cycle(1'b1, 1'b0, 2, 15);
        idle(9);

        // Back-to-back bursts of two, then strobe toggling during a burst.
        repeat (4) cycle(1'b1, 1'b0, 1, 2);
        idle(1);
        cycle(1'b1, 1'b0, 0, 5);
        for (int i = 0; i < 4; i++) cycle(1'b1, (i % 2) == 1, 3, 7);
        idle(3);

        // Reset on the second beat of an 8-beat burst.
        cycle(1'b1, 1'b0, 0, 8);
        cycle(1'b0, 1'b0, 0, 8);
        idle(8);

        // Randomized traffic with live register churn.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, NUM_REGS-1)] = $urandom;
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 9) < 3,
                  int'($urandom_range(0, (1 << ADDR_W) - 1)),
                  int'($urandom_range(0, (1 << BURST_W) - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
